// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_sync_gen
//  Purpose  : Raster timing generator. Produces pixel coordinates,
//             display-enable, hsync/vsync and line/frame strobes, all
//             registered one cycle after the internal counters so that
//             every output refers to the same (x,y) in the same cycle.
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       de,
   output logic       hs,
   output logic       vs,
   output logic       line_start,
   output logic       frame_start,
   output logic [7:0] frame_cnt
);

   // Totals and decode boundaries. Boundaries are kept 11 bits wide so a
   // timing whose total is exactly 1024 still compares correctly.
   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0]  c_H_LAST   = 10'(c_H_TOTAL - 1);
   localparam logic [9:0]  c_V_LAST   = 10'(c_V_TOTAL - 1);
   localparam logic [10:0] c_H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] c_HS_BEG   = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] c_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] c_V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] c_VS_BEG   = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] c_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   // Counters are 10 bits wide; reject timings that cannot be represented.
   generate
      if (c_H_TOTAL > 1024) begin : g_h_total_too_large
         $error("vga_sync_gen: H_TOTAL must be 1024 or less");
      end
      if (c_V_TOTAL > 1024) begin : g_v_total_too_large
         $error("vga_sync_gen: V_TOTAL must be 1024 or less");
      end
   endgenerate

   logic [9:0]  r_h_cnt;
   logic [9:0]  r_v_cnt;

   logic        w_h_last;
   logic        w_v_last;
   logic [10:0] w_h_ext;
   logic [10:0] w_v_ext;
   logic        w_de;
   logic        w_hs_on;
   logic        w_vs_on;
   logic        w_line;
   logic        w_frame;

   // Decode of the current (pre-increment) counter position.
   always_comb begin
      w_h_ext  = {1'b0, r_h_cnt};
      w_v_ext  = {1'b0, r_v_cnt};
      w_h_last = (r_h_cnt == c_H_LAST);
      w_v_last = (r_v_cnt == c_V_LAST);
      w_de     = (w_h_ext < c_H_ACT) && (w_v_ext < c_V_ACT);
      w_hs_on  = (w_h_ext >= c_HS_BEG) && (w_h_ext < c_HS_END);
      w_vs_on  = (w_v_ext >= c_VS_BEG) && (w_v_ext < c_VS_END);
      w_line   = (r_h_cnt == 10'd0);
      w_frame  = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
   end

   // Horizontal/vertical position counters; frozen while en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_h_cnt <= 10'd0;
         r_v_cnt <= 10'd0;
      end else if (en) begin
         if (w_h_last) begin
            r_h_cnt <= 10'd0;
            if (w_v_last) begin
               r_v_cnt <= 10'd0;
            end else begin
               r_v_cnt <= r_v_cnt + 10'd1;
            end
         end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
         end
      end
   end

   // Output register stage: all outputs describe the position just counted,
   // and hold (pulses included) while en is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x           <= 10'd0;
         y           <= 10'd0;
         de          <= 1'b0;
         hs          <= ~SYNC_POL;
         vs          <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         frame_cnt   <= 8'd0;
      end else if (en) begin
         x           <= r_h_cnt;
         y           <= r_v_cnt;
         de          <= w_de;
         hs          <= w_hs_on ? SYNC_POL : ~SYNC_POL;
         vs          <= w_vs_on ? SYNC_POL : ~SYNC_POL;
         line_start  <= w_line;
         frame_start <= w_frame;
         if (w_frame) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_gen
//  Purpose  : Directed self-checking bench for vga_sync_gen, using a reduced
//             raster (16 x 10 total) so whole frames and the frame counter
//             wrap fit in a short run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync_gen;

   // Reduced timing: H = 8 + 2 + 3 + 3 = 16, V = 6 + 1 + 2 + 1 = 10.
   // hsync low for x = 10..12, vsync low for y = 7..8, 160 cycles per frame.
   localparam int HT = 16;
   localparam int VT = 10;
   localparam int FRAME = HT * VT;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [9:0] x;
   logic [9:0] y;
   logic       de;
   logic       hs;
   logic       vs;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_cnt;

   int checks = 0;
   int errors = 0;

   vga_sync_gen #(
      .H_ACTIVE (8),
      .H_FP     (2),
      .H_SYNC   (3),
      .H_BP     (3),
      .V_ACTIVE (6),
      .V_FP     (1),
      .V_SYNC   (2),
      .V_BP     (1),
      .SYNC_POL (1'b0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .x           (x),
      .y           (y),
      .de          (de),
      .hs          (hs),
      .vs          (vs),
      .line_start  (line_start),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt)
   );

   // 10 time-unit pixel clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and sample 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Packs {x, y, de, hs, vs, line_start, frame_start} for compact compares.
   function automatic logic [31:0] pack(input logic [9:0] px, input logic [9:0] py,
                                        input logic pde, input logic phs, input logic pvs,
                                        input logic pls, input logic pfs);
      return {7'd0, px, py, pde, phs, pvs, pls, pfs};
   endfunction

   function automatic logic [31:0] reset_vec();
      return pack(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
   endfunction

   initial begin
      logic [9:0] ex;
      logic [9:0] ey;
      logic [31:0] exp_vec;

      // ---- Reset without any clock edge -------------------------------
      en = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("async_reset_outputs", pack(x, y, de, hs, vs, line_start, frame_start), reset_vec());
      check("async_reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);

      // Reset held across edges keeps everything at reset values.
      step(2);
      check("reset_held_outputs", pack(x, y, de, hs, vs, line_start, frame_start), reset_vec());

      // ---- Release and first edge -------------------------------------
      rst = 1'b0;
      step(1);
      check("first_edge_outputs", pack(x, y, de, hs, vs, line_start, frame_start),
            pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
      check("first_edge_frame_cnt", {24'd0, frame_cnt}, 32'd1);

      // ---- One full frame, cycle by cycle -------------------------------
      for (int i = 0; i < FRAME; i++) begin
         if (i != 0) step(1);
         ex = 10'(i % HT);
         ey = 10'(i / HT);
         exp_vec = pack(ex, ey,
                        (ex < 10'd8) && (ey < 10'd6),
                        !((ex >= 10'd10) && (ex <= 10'd12)),
                        !((ey >= 10'd7) && (ey <= 10'd8)),
                        (ex == 10'd0),
                        (i == 0));
         check($sformatf("frame_cycle_%0d", i),
               pack(x, y, de, hs, vs, line_start, frame_start), exp_vec);
         check($sformatf("frame_cnt_cycle_%0d", i), {24'd0, frame_cnt}, 32'd1);
      end

      // Wrap back to (0,0) exactly one frame later.
      step(1);
      check("second_frame_start", pack(x, y, de, hs, vs, line_start, frame_start),
            pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
      check("second_frame_cnt", {24'd0, frame_cnt}, 32'd2);

      // Mid-frame frame_cnt stays put.
      step(FRAME / 2);
      check("mid_frame_cnt_steady", {24'd0, frame_cnt}, 32'd2);
      check("mid_frame_no_pulse", {31'd0, frame_start}, 32'd0);
      step(FRAME - FRAME / 2);

      // ---- frame_cnt through 255 -> 0 -> 1 ------------------------------
      for (int f = 3; f <= 257; f++) begin
         if (f != 3) step(FRAME);
         check($sformatf("wrap_frame_start_%0d", f), {31'd0, frame_start}, 32'd1);
         check($sformatf("wrap_frame_cnt_%0d", f), {24'd0, frame_cnt}, 32'(f % 256));
      end
      check("wrap_position", {12'd0, x, y}, 32'd0);

      // ---- Stall mid-line at (5,2) --------------------------------------
      step(2 * HT + 5);
      check("stall_pre_position", {12'd0, x, y}, {12'd0, 10'd5, 10'd2});
      en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step(1);
         check($sformatf("stall_hold_%0d", k), pack(x, y, de, hs, vs, line_start, frame_start),
               pack(10'd5, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
      end
      en = 1'b1;
      step(1);
      check("stall_resume", pack(x, y, de, hs, vs, line_start, frame_start),
            pack(10'd6, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

      // ---- Stall landing on frame_start ---------------------------------
      step(FRAME - (2 * HT + 6));
      check("stall_fs_pulse", {31'd0, frame_start}, 32'd1);
      check("stall_fs_cnt", {24'd0, frame_cnt}, 32'd2);
      en = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step(1);
         check($sformatf("stall_fs_hold_%0d", k), {22'd0, x, frame_start, frame_cnt},
               {22'd0, 10'd0, 1'b1, 8'd2});
      end
      en = 1'b1;
      step(1);
      check("stall_fs_release", {22'd0, x, frame_start, frame_cnt},
            {22'd0, 10'd1, 1'b0, 8'd2});

      // ---- Asynchronous reset mid-frame at (11,7): hs and vs both low ----
      step(7 * HT + 11 - 1);
      check("pre_reset_outputs", pack(x, y, de, hs, vs, line_start, frame_start),
            pack(10'd11, 10'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      #2 rst = 1'b1;
      #1;
      check("midrun_reset_outputs", pack(x, y, de, hs, vs, line_start, frame_start), reset_vec());
      check("midrun_reset_frame_cnt", {24'd0, frame_cnt}, 32'd0);
      step(1);
      #3 rst = 1'b0;
      step(1);
      check("restart_outputs", pack(x, y, de, hs, vs, line_start, frame_start),
            pack(10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
      check("restart_frame_cnt", {24'd0, frame_cnt}, 32'd1);
      step(1);
      check("restart_advance", pack(x, y, de, hs, vs, line_start, frame_start),
            pack(10'd1, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Pixel-timing stage that sits directly downstream of the board top's PLL/POR logic.
- Runs on the 25.125 MHz pixel clock and is reset by the POR-delayed reset.
- Produces pixel coordinates, display-enable, hsync/vsync and frame/line strobes, all pipeline-aligned, for the colour-generation logic in vga.
- Default timing is 640x480@60 (800x525 total).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, sync asserted level (0 = active-low, 1 = active-high)

Ports:
clk  input  1  pixel clock
rst  input  1  asynchronous, active-high reset
en  input  1  advance enable; low stalls the generator
x  output  10  current horizontal position, 0..H_TOTAL-1
y  output  10  current vertical position, 0..V_TOTAL-1
de  output  1  high when x<H_ACTIVE and y<V_ACTIVE
hs  output  1  horizontal sync
vs  output  1  vertical sync
line_start  output  1  one-cycle pulse when x==0
frame_start  output  1  one-cycle pulse when x==0 and y==0
frame_cnt  output  8  frames started since reset, wrapping

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise. Both must be 1024 or less; elaboration fails otherwise.
- Reset is asynchronous, active-high, and applies to every register:
  - Internal counters h_cnt and v_cnt = 0.
  - Outputs: x=0, y=0, de=0, line_start=0, frame_start=0, frame_cnt=0.
  - hs and vs = deasserted level (~SYNC_POL).
- Counters, on each rising clk with en=1:
  - h_cnt increments.
  - At h_cnt==H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when both h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
- Outputs are registered and decoded from the pre-increment counter values. Latency is one cycle from counter to output, and all outputs refer to the same (x,y) in the same cycle.
- hs = SYNC_POL when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, otherwise ~SYNC_POL. vs uses the same rule on y with the V_* parameters.
- frame_cnt increments (mod 256) in the same cycle frame_start is registered high.
- Stall: with en=0, counters and all outputs hold their values, including the pulse outputs.
  - A held line_start/frame_start counts as one event. Consumers qualify pulses with en.
  - frame_cnt does not increment again while stalled.
- First cycles after reset: the first en=1 edge registers position (0,0): de=1, line_start=1, frame_start=1, frame_cnt=1.
- Reset mid-frame returns immediately (asynchronously) to the reset values. No partial-frame state survives.
- No combinational path from en to any output.

Test Plan:
- Reset and start: assert rst, hold en=1. All outputs must take reset values with no clock edge (hs=vs=1). Release rst, then on the first edge require x=0, y=0, de=1, frame_start=1, line_start=1, frame_cnt=1.
- Horizontal timing: over one line with en=1, count de high for exactly 640 cycles (x 0..639). hs must be low exactly while x=656..751 (96 cycles), and line_start must repeat every 800 cycles.
- Vertical timing: over one frame, vs must be low exactly for y=490..491 (1600 cycles), de must be 0 for all y>=480, and frame_start must repeat every 420000 cycles. No x>799 or y>524 may ever appear.
- frame_cnt wrap: run 256 frames. frame_cnt must go 255 -> 0 at the 256th frame_start, one increment per frame.
- Stall: drop en for 7 cycles at x=100, y=5. Outputs must hold x=100, y=5, de=1 for those cycles, then resume x=101. Repeat with the stall landing on frame_start and confirm frame_cnt rises by exactly 1.
- Reset mid-operation: assert rst asynchronously (between edges) at x=700, y=300. Outputs must go to reset values before the next edge. After release the sequence must restart at (0,0) with frame_cnt=1.
